// File: rtl/seq_pkg.sv
// Shared constants for the 8-bit processor control sequencer: opcodes,
// T-state indices and control-word bit positions.
package seq_pkg;

    localparam int NUM_T    = 6;
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_JMP = 4'b0011;
    localparam logic [OPCODE_W-1:0] OP_JC  = 4'b0100;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 4'b0101;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    localparam logic [NUM_T-1:0] T1_ONEHOT = 6'b000001;

    localparam int CW_PC_INC   = 0;
    localparam int CW_PC_OUT   = 1;
    localparam int CW_PC_LOAD  = 2;
    localparam int CW_MAR_LOAD = 3;
    localparam int CW_RAM_OUT  = 4;
    localparam int CW_IR_LOAD  = 5;
    localparam int CW_IR_OUT   = 6;
    localparam int CW_A_LOAD   = 7;
    localparam int CW_A_OUT    = 8;
    localparam int CW_B_LOAD   = 9;
    localparam int CW_ALU_SUB  = 10;
    localparam int CW_ALU_OUT  = 11;
    localparam int CW_OUT_LOAD = 12;
    localparam int CW_W        = 13;

    typedef logic [CW_W-1:0] ctrl_word_t;

    function automatic ctrl_word_t cw_bit(input int pos);
        cw_bit = ctrl_word_t'(1) << pos;
    endfunction

endpackage

// File: rtl/tstate_ring.sv
// One-hot T-state ring: holds on hold_i, stays frozen on freeze_i, and
// returns to T1 when the current instruction signals done (T6 always wraps).
module tstate_ring
    import seq_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             hold_i,
    input  logic             done_i,
    input  logic             freeze_i,
    output logic [NUM_T-1:0] tstate_o
);

    logic [NUM_T-1:0] tstate_q;
    logic [NUM_T-1:0] tstate_d;

    always_comb begin
        tstate_d = tstate_q;
        if (!freeze_i && !hold_i) begin
            if (done_i || tstate_q[T6_IDX]) begin
                tstate_d = T1_ONEHOT;
            end else begin
                tstate_d = {tstate_q[NUM_T-2:0], tstate_q[NUM_T-1]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tstate_q <= T1_ONEHOT;
        end else begin
            tstate_q <= tstate_d;
        end
    end

    assign tstate_o = tstate_q;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: opcode decode to the datapath control word
// plus the sticky halted flag. Define SEQ_JUMP_EN to add JMP/JC/JZ.
module control_sequencer
    import seq_pkg::*;
(
    input  logic                clk_i,
    input  logic                clr_n_i,
    input  logic                run_i,
    input  logic [OPCODE_W-1:0] opcode_i,
    input  logic                carry_flag_i,
    input  logic                zero_flag_i,
    output logic [NUM_T-1:0]    tstate_o,
    output logic                pc_inc_o,
    output logic                pc_out_o,
    output logic                pc_load_o,
    output logic                mar_load_o,
    output logic                ram_out_o,
    output logic                ir_load_o,
    output logic                ir_out_o,
    output logic                a_load_o,
    output logic                a_out_o,
    output logic                b_load_o,
    output logic                alu_sub_o,
    output logic                alu_out_o,
    output logic                out_load_o,
    output logic                halted_o
);

    logic             halted_q;
    logic             advance;
    logic             done;
    logic [NUM_T-1:0] tstate;
    ctrl_word_t       cw;
    ctrl_word_t       cw_gated;

    assign advance = run_i && !halted_q;

    tstate_ring u_ring (
        .clk_i    (clk_i),
        .rst_n_i  (clr_n_i),
        .hold_i   (!run_i),
        .done_i   (done),
        .freeze_i (halted_q),
        .tstate_o (tstate)
    );

    // Unreachable or corrupted ring states fall through with done set so the ring recovers at T1.
    always_comb begin
        cw   = '0;
        done = 1'b0;
        if (tstate[T1_IDX]) begin
            cw = cw_bit(CW_PC_OUT) | cw_bit(CW_MAR_LOAD);
        end else if (tstate[T2_IDX]) begin
            cw = cw_bit(CW_PC_INC);
        end else if (tstate[T3_IDX]) begin
            cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_IR_LOAD);
        end else if (tstate[T4_IDX]) begin
            case (opcode_i)
                OP_LDA, OP_ADD, OP_SUB: cw = cw_bit(CW_IR_OUT) | cw_bit(CW_MAR_LOAD);
                OP_OUT: begin
                    cw   = cw_bit(CW_A_OUT) | cw_bit(CW_OUT_LOAD);
                    done = 1'b1;
                end
`ifdef SEQ_JUMP_EN
                OP_JMP: begin
                    cw   = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                    done = 1'b1;
                end
                OP_JC: begin
                    if (carry_flag_i) cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                    done = 1'b1;
                end
                OP_JZ: begin
                    if (zero_flag_i) cw = cw_bit(CW_IR_OUT) | cw_bit(CW_PC_LOAD);
                    done = 1'b1;
                end
`endif
                default: done = 1'b1;
            endcase
        end else if (tstate[T5_IDX]) begin
            case (opcode_i)
                OP_LDA: begin
                    cw   = cw_bit(CW_RAM_OUT) | cw_bit(CW_A_LOAD);
                    done = 1'b1;
                end
                OP_ADD, OP_SUB: cw = cw_bit(CW_RAM_OUT) | cw_bit(CW_B_LOAD);
                default: done = 1'b1;
            endcase
        end else if (tstate[T6_IDX]) begin
            done = 1'b1;
            if (opcode_i == OP_ADD) begin
                cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD);
            end else if (opcode_i == OP_SUB) begin
                cw = cw_bit(CW_ALU_OUT) | cw_bit(CW_A_LOAD) | cw_bit(CW_ALU_SUB);
            end
        end else begin
            done = 1'b1;
        end
    end

    // HLT is taken only when the T4 edge actually advances; the ring itself returns to T1 via done.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            halted_q <= 1'b0;
        end else if (advance && tstate[T4_IDX] && opcode_i == OP_HLT) begin
            halted_q <= 1'b1;
        end
    end

    assign cw_gated = (clr_n_i && advance) ? cw : '0;

    assign tstate_o   = tstate;
    assign halted_o   = halted_q;
    assign pc_inc_o   = cw_gated[CW_PC_INC];
    assign pc_out_o   = cw_gated[CW_PC_OUT];
    assign mar_load_o = cw_gated[CW_MAR_LOAD];
    assign ram_out_o  = cw_gated[CW_RAM_OUT];
    assign ir_load_o  = cw_gated[CW_IR_LOAD];
    assign ir_out_o   = cw_gated[CW_IR_OUT];
    assign a_load_o   = cw_gated[CW_A_LOAD];
    assign a_out_o    = cw_gated[CW_A_OUT];
    assign b_load_o   = cw_gated[CW_B_LOAD];
    assign alu_sub_o  = cw_gated[CW_ALU_SUB];
    assign alu_out_o  = cw_gated[CW_ALU_OUT];
    assign out_load_o = cw_gated[CW_OUT_LOAD];

`ifdef SEQ_JUMP_EN
    assign pc_load_o = cw_gated[CW_PC_LOAD];
`else
    logic unused_jump_inputs;
    assign unused_jump_inputs = ^{carry_flag_i, zero_flag_i, cw_gated[CW_PC_LOAD]};
    assign pc_load_o = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: directed per-cycle vectors push
// expected tstate/strobes/halted; a negedge monitor pops and compares.
module tb_control_sequencer;

    localparam logic [12:0] M_PC_INC   = 13'h1000;
    localparam logic [12:0] M_PC_OUT   = 13'h0800;
    localparam logic [12:0] M_PC_LOAD  = 13'h0400;
    localparam logic [12:0] M_MAR_LOAD = 13'h0200;
    localparam logic [12:0] M_RAM_OUT  = 13'h0100;
    localparam logic [12:0] M_IR_LOAD  = 13'h0080;
    localparam logic [12:0] M_IR_OUT   = 13'h0040;
    localparam logic [12:0] M_A_LOAD   = 13'h0020;
    localparam logic [12:0] M_A_OUT    = 13'h0010;
    localparam logic [12:0] M_B_LOAD   = 13'h0008;
    localparam logic [12:0] M_ALU_SUB  = 13'h0004;
    localparam logic [12:0] M_ALU_OUT  = 13'h0002;
    localparam logic [12:0] M_OUT_LOAD = 13'h0001;

    localparam logic [12:0] F1 = M_PC_OUT | M_MAR_LOAD;
    localparam logic [12:0] F2 = M_PC_INC;
    localparam logic [12:0] F3 = M_RAM_OUT | M_IR_LOAD;
    localparam logic [12:0] NONE = 13'h0000;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    localparam logic [3:0] LDA = 4'b0000;
    localparam logic [3:0] ADD = 4'b0001;
    localparam logic [3:0] SUB = 4'b0010;
    localparam logic [3:0] JZ  = 4'b0101;
    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] OUT = 4'b1110;
    localparam logic [3:0] HLT = 4'b1111;

    typedef struct {
        string       name;
        logic [5:0]  tstate;
        logic [12:0] cw;
        logic        halted;
    } expect_t;

    logic        clk = 1'b0;
    logic        clrN = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic        carryFlag = 1'b0;
    logic        zeroFlag = 1'b0;
    logic [5:0]  tstate;
    logic        pcInc, pcOut, pcLoad, marLoad, ramOut, irLoad, irOut;
    logic        aLoad, aOut, bLoad, aluSub, aluOut, outLoad, halted;

    expect_t     expQ[$];
    int          assertCount = 0;
    int          failCount = 0;

    control_sequencer dut (
        .clk_i        (clk),
        .clr_n_i      (clrN),
        .run_i        (run),
        .opcode_i     (opcode),
        .carry_flag_i (carryFlag),
        .zero_flag_i  (zeroFlag),
        .tstate_o     (tstate),
        .pc_inc_o     (pcInc),
        .pc_out_o     (pcOut),
        .pc_load_o    (pcLoad),
        .mar_load_o   (marLoad),
        .ram_out_o    (ramOut),
        .ir_load_o    (irLoad),
        .ir_out_o     (irOut),
        .a_load_o     (aLoad),
        .a_out_o      (aOut),
        .b_load_o     (bLoad),
        .alu_sub_o    (aluSub),
        .alu_out_o    (aluOut),
        .out_load_o   (outLoad),
        .halted_o     (halted)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input string name, input logic clrV, input logic runV,
                                 input logic [3:0] opc, input logic c, input logic z,
                                 input logic [5:0] eT, input logic [12:0] eCw, input logic eH);
        expect_t e;
        @(posedge clk);
        #1;
        clrN = clrV;
        run = runV;
        opcode = opc;
        carryFlag = c;
        zeroFlag = z;
        e.name = name;
        e.tstate = eT;
        e.cw = eCw;
        e.halted = eH;
        expQ.push_back(e);
    endtask

    task automatic checkOutput();
        expect_t     e;
        logic [12:0] cwAct;
        e = expQ.pop_front();
        cwAct = {pcInc, pcOut, pcLoad, marLoad, ramOut, irLoad, irOut,
                 aLoad, aOut, bLoad, aluSub, aluOut, outLoad};
        assertCount++;
        if (tstate !== e.tstate) begin
            failCount++;
            $display("[TB] FAIL %s tstate: got %b expected %b", e.name, tstate, e.tstate);
        end
        assertCount++;
        if (cwAct !== e.cw) begin
            failCount++;
            $display("[TB] FAIL %s strobes: got %b expected %b", e.name, cwAct, e.cw);
        end
        assertCount++;
        if (halted !== e.halted) begin
            failCount++;
            $display("[TB] FAIL %s halted: got %b expected %b", e.name, halted, e.halted);
        end
    endtask

    // Monitor: one scoreboard entry per cycle, plus the single-bus-driver check.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput();
            assertCount++;
            assert ($onehot0({pcOut, ramOut, irOut, aOut, aluOut}))
            else begin
                failCount++;
                $display("[TB] FAIL bus_drivers: got %b expected at most one high",
                         {pcOut, ramOut, irOut, aOut, aluOut});
            end
        end
    end

    initial begin
        // Reset held, then LDA fetch/execute
        applyStimulus("reset",    1'b0, 1'b1, LDA, 0, 0, T1, NONE, 1'b0);
        applyStimulus("lda_t1",   1'b1, 1'b1, LDA, 0, 0, T1, F1, 1'b0);
        applyStimulus("lda_t2",   1'b1, 1'b1, LDA, 0, 0, T2, F2, 1'b0);
        applyStimulus("lda_t3",   1'b1, 1'b1, LDA, 0, 0, T3, F3, 1'b0);
        applyStimulus("lda_t4",   1'b1, 1'b1, LDA, 0, 0, T4, M_IR_OUT | M_MAR_LOAD, 1'b0);
        applyStimulus("lda_t5",   1'b1, 1'b1, LDA, 0, 0, T5, M_RAM_OUT | M_A_LOAD, 1'b0);
        applyStimulus("lda_wrap", 1'b1, 1'b1, SUB, 0, 0, T1, F1, 1'b0);

        // SUB through T6 and wrap
        applyStimulus("sub_t2",   1'b1, 1'b1, SUB, 0, 0, T2, F2, 1'b0);
        applyStimulus("sub_t3",   1'b1, 1'b1, SUB, 0, 0, T3, F3, 1'b0);
        applyStimulus("sub_t4",   1'b1, 1'b1, SUB, 0, 0, T4, M_IR_OUT | M_MAR_LOAD, 1'b0);
        applyStimulus("sub_t5",   1'b1, 1'b1, SUB, 0, 0, T5, M_RAM_OUT | M_B_LOAD, 1'b0);
        applyStimulus("sub_t6",   1'b1, 1'b1, SUB, 0, 0, T6, M_ALU_OUT | M_A_LOAD | M_ALU_SUB, 1'b0);
        applyStimulus("sub_wrap", 1'b1, 1'b1, OUT, 0, 0, T1, F1, 1'b0);

        // OUT then HLT
        applyStimulus("out_t2",   1'b1, 1'b1, OUT, 0, 0, T2, F2, 1'b0);
        applyStimulus("out_t3",   1'b1, 1'b1, OUT, 0, 0, T3, F3, 1'b0);
        applyStimulus("out_t4",   1'b1, 1'b1, OUT, 0, 0, T4, M_A_OUT | M_OUT_LOAD, 1'b0);
        applyStimulus("hlt_t1",   1'b1, 1'b1, HLT, 0, 0, T1, F1, 1'b0);
        applyStimulus("hlt_t2",   1'b1, 1'b1, HLT, 0, 0, T2, F2, 1'b0);
        applyStimulus("hlt_t3",   1'b1, 1'b1, HLT, 0, 0, T3, F3, 1'b0);
        applyStimulus("hlt_t4",   1'b1, 1'b1, HLT, 0, 0, T4, NONE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus("halted", 1'b1, (i % 5) != 3, ADD, 0, 0, T1, NONE, 1'b1);
        end
        applyStimulus("hlt_clr",  1'b0, 1'b1, ADD, 0, 0, T1, NONE, 1'b0);

        // ADD paused at T5 for three cycles
        applyStimulus("add_t1",   1'b1, 1'b1, ADD, 0, 0, T1, F1, 1'b0);
        applyStimulus("add_t2",   1'b1, 1'b1, ADD, 0, 0, T2, F2, 1'b0);
        applyStimulus("add_t3",   1'b1, 1'b1, ADD, 0, 0, T3, F3, 1'b0);
        applyStimulus("add_t4",   1'b1, 1'b1, ADD, 0, 0, T4, M_IR_OUT | M_MAR_LOAD, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus("add_pause", 1'b1, 1'b0, ADD, 0, 0, T5, NONE, 1'b0);
        end
        applyStimulus("add_t5",   1'b1, 1'b1, ADD, 0, 0, T5, M_RAM_OUT | M_B_LOAD, 1'b0);
        applyStimulus("add_t6",   1'b1, 1'b1, ADD, 0, 0, T6, M_ALU_OUT | M_A_LOAD, 1'b0);
        applyStimulus("add_wrap", 1'b1, 1'b1, LDA, 0, 0, T1, F1, 1'b0);

        // Asynchronous reset in the middle of T5
        applyStimulus("rst_t2",   1'b1, 1'b1, LDA, 0, 0, T2, F2, 1'b0);
        applyStimulus("rst_t3",   1'b1, 1'b1, LDA, 0, 0, T3, F3, 1'b0);
        applyStimulus("rst_t4",   1'b1, 1'b1, LDA, 0, 0, T4, M_IR_OUT | M_MAR_LOAD, 1'b0);
        applyStimulus("rst_mid",  1'b0, 1'b1, LDA, 0, 0, T1, NONE, 1'b0);
        applyStimulus("rst_t1",   1'b1, 1'b1, JZ,  0, 1, T1, F1, 1'b0);

        // JZ taken / not taken, then an undefined opcode as NOP
        applyStimulus("jz1_t2",   1'b1, 1'b1, JZ,  0, 1, T2, F2, 1'b0);
        applyStimulus("jz1_t3",   1'b1, 1'b1, JZ,  0, 1, T3, F3, 1'b0);
`ifdef SEQ_JUMP_EN
        applyStimulus("jz1_t4",   1'b1, 1'b1, JZ,  0, 1, T4, M_IR_OUT | M_PC_LOAD, 1'b0);
`else
        applyStimulus("jz1_t4",   1'b1, 1'b1, JZ,  0, 1, T4, NONE, 1'b0);
`endif
        applyStimulus("jz0_t1",   1'b1, 1'b1, JZ,  1, 0, T1, F1, 1'b0);
        applyStimulus("jz0_t2",   1'b1, 1'b1, JZ,  1, 0, T2, F2, 1'b0);
        applyStimulus("jz0_t3",   1'b1, 1'b1, JZ,  1, 0, T3, F3, 1'b0);
        applyStimulus("jz0_t4",   1'b1, 1'b1, JZ,  1, 0, T4, NONE, 1'b0);
        applyStimulus("nop_t1",   1'b1, 1'b1, NOP, 1, 1, T1, F1, 1'b0);
        applyStimulus("nop_t2",   1'b1, 1'b1, NOP, 1, 1, T2, F2, 1'b0);
        applyStimulus("nop_t3",   1'b1, 1'b1, NOP, 1, 1, T3, F3, 1'b0);
        applyStimulus("nop_t4",   1'b1, 1'b1, NOP, 1, 1, T4, NONE, 1'b0);
        applyStimulus("nop_wrap", 1'b1, 1'b1, LDA, 0, 0, T1, F1, 1'b0);

        for (int k = 0; k < 10 && expQ.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (expQ.size() > 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL drain: got %0d pending entries expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
